// File: rtl/sampled_history_tracker.sv
// sampled_history_tracker
// Multi-channel synthesizable equivalent of the gated sampled-value functions
// $past(x,N,en), $rose, $fell, $stable and $changed. Each channel keeps a
// shift history of values captured on enabled clock edges. The tap read is
// purely from registers, so there is no combinational path from smp to
// past_val. The edge/stability flags are registered one-cycle pulses.
module sampled_history_tracker #(
  parameter int                 WIDTH    = 8,
  parameter int                 CHANNELS = 4,
  parameter int                 DEPTH    = 8,
  parameter logic [WIDTH-1:0]   INIT     = '0,
  localparam int                NW       = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic [CHANNELS*WIDTH-1:0]    smp,
  input  logic [NW-1:0]                past_n,
  output logic [CHANNELS*WIDTH-1:0]    past_val,
  output logic                         past_vld,
  output logic [CHANNELS-1:0]          rose,
  output logic [CHANNELS-1:0]          fell,
  output logic [CHANNELS-1:0]          stable,
  output logic [CHANNELS-1:0]          changed,
  output logic [NW-1:0]                fill
);

  // Slot 0 holds the most recent enabled sample of each channel.
  logic [WIDTH-1:0]    hist_q [CHANNELS][DEPTH];
  logic [WIDTH-1:0]    hist_d [CHANNELS][DEPTH];
  logic [NW-1:0]       fill_q, fill_d;
  logic [CHANNELS-1:0] rose_q, rose_d;
  logic [CHANNELS-1:0] fell_q, fell_d;
  logic [CHANNELS-1:0] stable_q, stable_d;
  logic [CHANNELS-1:0] changed_q, changed_d;

  logic [WIDTH-1:0]    cur;
  logic [WIDTH-1:0]    prev;
  logic [NW-1:0]       n_eff;

  // Next-state: history shift/flush, fill count, and flag pulses.
  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    rose_d    = '0;
    fell_d    = '0;
    stable_d  = '0;
    changed_d = '0;
    cur       = INIT;
    prev      = INIT;

    if (flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          hist_d[c][k] = INIT;
        end
        if (en) begin
          hist_d[c][0] = smp[c*WIDTH +: WIDTH];
        end
      end
      fill_d = en ? NW'(1) : '0;
    end else if (en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          hist_d[c][k] = hist_q[c][k-1];
        end
        hist_d[c][0] = smp[c*WIDTH +: WIDTH];
      end
      fill_d = (fill_q == NW'(DEPTH)) ? fill_q : fill_q + NW'(1);
    end

    // A flushing edge compares against INIT, as if no past existed.
    if (en) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cur          = smp[c*WIDTH +: WIDTH];
        prev         = flush ? INIT : hist_q[c][0];
        rose_d[c]    = cur[0] & ~prev[0];
        fell_d[c]    = ~cur[0] & prev[0];
        stable_d[c]  = (cur == prev);
        changed_d[c] = (cur != prev);
      end
    end
  end

  // State registers; every register is cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          hist_q[c][k] <= INIT;
        end
      end
      fill_q    <= '0;
      rose_q    <= '0;
      fell_q    <= '0;
      stable_q  <= '0;
      changed_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          hist_q[c][k] <= hist_d[c][k];
        end
      end
      fill_q    <= fill_d;
      rose_q    <= rose_d;
      fell_q    <= fell_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  // Tap read: N=0 aliases to N=1; taps beyond the history return INIT.
  always_comb begin
    n_eff    = (past_n == '0) ? NW'(1) : past_n;
    past_val = {CHANNELS{INIT}};
    past_vld = 1'b0;
    if (n_eff <= NW'(DEPTH)) begin
      past_vld = (fill_q >= n_eff);
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (n_eff == NW'(k + 1)) begin
            past_val[c*WIDTH +: WIDTH] = hist_q[c][k];
          end
        end
      end
    end
  end

  assign fill    = fill_q;
  assign rose    = rose_q;
  assign fell    = fell_q;
  assign stable  = stable_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_sampled_history_tracker.sv
// Directed bench for sampled_history_tracker (WIDTH=8, CHANNELS=4, DEPTH=8, INIT=0).
module tb_sampled_history_tracker;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int D  = 8;
  localparam int NW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              flush;
  logic [CH*W-1:0]   smp;
  logic [NW-1:0]     past_n;
  logic [CH*W-1:0]   past_val;
  logic              past_vld;
  logic [CH-1:0]     rose, fell, stable, changed;
  logic [NW-1:0]     fill;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  sampled_history_tracker #(
    .WIDTH(W), .CHANNELS(CH), .DEPTH(D), .INIT(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .smp(smp),
    .past_n(past_n), .past_val(past_val), .past_vld(past_vld),
    .rose(rose), .fell(fell), .stable(stable), .changed(changed),
    .fill(fill)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: one clock edge with the given controls; channel c carries v+c.
  task automatic apply(input logic e, input logic f, input logic [W-1:0] v);
    en    = e;
    flush = f;
    for (int c = 0; c < CH; c++) smp[c*W +: W] = v + W'(c);
    @(posedge clk);
    #1;
    en    = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; flush = 1'b0; smp = '0; past_n = 4'd1;
    #2;
    checks++; if (fill !== 4'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
    checks++; if (past_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", past_vld); end
    checks++; if (past_val !== 32'h0) begin failures++; $display("FAIL reset_val got=%h exp=0", past_val); end
    checks++; if ({rose, fell, stable, changed} !== 16'h0) begin
      failures++; $display("FAIL reset_flags got=%h exp=0", {rose, fell, stable, changed});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    apply(1'b1, 1'b0, 8'h11);
    apply(1'b1, 1'b0, 8'h22);
    apply(1'b1, 1'b0, 8'h33);
    past_n = 4'd2; #1;
    checks++; if (past_val[7:0] !== 8'h22) begin failures++; $display("FAIL basic_n2_ch0 got=%h exp=22", past_val[7:0]); end
    checks++; if (past_val[15:8] !== 8'h23) begin failures++; $display("FAIL basic_n2_ch1 got=%h exp=23", past_val[15:8]); end
    checks++; if (past_vld !== 1'b1) begin failures++; $display("FAIL basic_vld got=%b exp=1", past_vld); end
    checks++; if (fill !== 4'd3) begin failures++; $display("FAIL basic_fill got=%0d exp=3", fill); end
    past_n = 4'd0; #1;
    checks++; if (past_val[7:0] !== 8'h33) begin failures++; $display("FAIL basic_n0 got=%h exp=33", past_val[7:0]); end
    past_n = 4'd4; #1;
    checks++; if (past_vld !== 1'b0 || past_val[7:0] !== 8'h00) begin
      failures++; $display("FAIL basic_n4 got vld=%b val=%h exp vld=0 val=00", past_vld, past_val[7:0]);
    end
  endtask

  task automatic test_gating();
    apply(1'b0, 1'b1, 8'h00);
    exp_q.delete();
    for (int i = 1; i <= 6; i++) begin
      apply(i % 2 == 1, 1'b0, W'(i));
      if (i % 2 == 1) exp_q.push_back(W'(i));
    end
    checks++; if ({rose, fell, stable, changed} !== 16'h0) begin
      failures++; $display("FAIL gating_flags_cleared got=%h exp=0", {rose, fell, stable, changed});
    end
    checks++; if (fill !== 4'd3) begin failures++; $display("FAIL gating_fill got=%0d exp=3", fill); end
    for (int k = 1; k <= 3; k++) begin
      past_n = NW'(k); #1;
      checks++;
      if (past_val[7:0] !== exp_q[exp_q.size() - k]) begin
        failures++; $display("FAIL gating_n%0d got=%h exp=%h", k, past_val[7:0], exp_q[exp_q.size() - k]);
      end
    end
  endtask

  task automatic test_flags();
    logic [W-1:0] vals [4];
    logic [3:0]   exp_f [4];  // {rose, fell, stable, changed} for ch0
    vals  = '{8'h00, 8'h01, 8'h01, 8'h00};
    exp_f = '{4'b0010, 4'b1001, 4'b0010, 4'b0101};
    apply(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, vals[i]);
      checks++;
      if ({rose[0], fell[0], stable[0], changed[0]} !== exp_f[i]) begin
        failures++; $display("FAIL flags_step%0d got=%b exp=%b", i, {rose[0], fell[0], stable[0], changed[0]}, exp_f[i]);
      end
    end
    apply(1'b0, 1'b0, 8'h55);
    checks++; if ({rose[0], fell[0], stable[0], changed[0]} !== 4'b0000) begin
      failures++; $display("FAIL flags_pulse_end got=%b exp=0000", {rose[0], fell[0], stable[0], changed[0]});
    end
  endtask

  task automatic test_saturate();
    apply(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < D + 3; i++) apply(1'b1, 1'b0, 8'h40 + W'(i));
    checks++; if (fill !== 4'd8) begin failures++; $display("FAIL sat_fill got=%0d exp=8", fill); end
    past_n = 4'd8; #1;
    checks++; if (past_val[7:0] !== 8'h43 || past_vld !== 1'b1) begin
      failures++; $display("FAIL sat_n8 got val=%h vld=%b exp val=43 vld=1", past_val[7:0], past_vld);
    end
    past_n = 4'd9; #1;
    checks++; if (past_val !== 32'h0 || past_vld !== 1'b0) begin
      failures++; $display("FAIL sat_n9 got val=%h vld=%b exp val=0 vld=0", past_val, past_vld);
    end
  endtask

  task automatic test_flush();
    apply(1'b1, 1'b1, 8'hAA);
    checks++; if (fill !== 4'd1) begin failures++; $display("FAIL flush_fill got=%0d exp=1", fill); end
    past_n = 4'd1; #1;
    checks++; if (past_val[7:0] !== 8'hAA) begin failures++; $display("FAIL flush_n1 got=%h exp=aa", past_val[7:0]); end
    past_n = 4'd2; #1;
    checks++; if (past_val[7:0] !== 8'h00 || past_vld !== 1'b0) begin
      failures++; $display("FAIL flush_n2 got val=%h vld=%b exp val=00 vld=0", past_val[7:0], past_vld);
    end
    // Same sample again under flush: previous value must be INIT, not 0xAA.
    apply(1'b1, 1'b1, 8'hAA);
    checks++; if ({stable[0], changed[0]} !== 2'b01) begin
      failures++; $display("FAIL flush_prev_init got=%b exp=01", {stable[0], changed[0]});
    end
    apply(1'b0, 1'b1, 8'h00);
    past_n = 4'd1; #1;
    checks++; if (fill !== 4'd0 || past_vld !== 1'b0 || past_val !== 32'h0) begin
      failures++; $display("FAIL flush_clear got fill=%0d vld=%b val=%h exp 0/0/0", fill, past_vld, past_val);
    end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 1'b0, 8'h00);
    apply(1'b1, 1'b0, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (fill !== 4'd0 || past_val !== 32'h0 || {rose, fell, stable, changed} !== 16'h0) begin
      failures++; $display("FAIL async_clear got fill=%0d val=%h flags=%h exp all 0", fill, past_val, {rose, fell, stable, changed});
    end
    #1;
    rst = 1'b0;
    apply(1'b1, 1'b0, 8'h01);
    checks++; if (rose[0] !== 1'b1 || fill !== 4'd1) begin
      failures++; $display("FAIL async_restart got rose=%b fill=%0d exp rose=1 fill=1", rose[0], fill);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gating();
    test_flags();
    test_saturate();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
